// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_param
// Brief    : Parametrised multi-port register file: two prioritised write ports,
//            optional write-to-read bypass, optional zero register and a busy
//            scoreboard for outstanding multi-cycle results.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             we0,
  input  logic [ADDR_WIDTH-1:0]            waddr0,
  input  logic [DATA_WIDTH-1:0]            wdata0,
  input  logic                             we1,
  input  logic [ADDR_WIDTH-1:0]            waddr1,
  input  logic [DATA_WIDTH-1:0]            wdata1,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rdata,
  output logic [READ_PORTS-1:0]            rbusy,
  input  logic                             busy_set,
  input  logic [ADDR_WIDTH-1:0]            busy_addr,
  output logic [(2**ADDR_WIDTH)-1:0]       busy_vec
);

  localparam int C_DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [C_DEPTH];
  logic [C_DEPTH-1:0]    r_busy;
  logic [C_DEPTH-1:0]    w_busy_nxt;
  logic                  w_wr0_ok;
  logic                  w_wr1_ok;

  assign w_wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr0_ok) r_regs[waddr0] <= wdata0;
      if (w_wr1_ok) r_regs[waddr1] <= wdata1;
    end
  end

  // Set is applied after clear: a new pending result outranks the retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we1)      w_busy_nxt[waddr1]    = 1'b0;
    if (busy_set) w_busy_nxt[busy_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

  generate
    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic [DATA_WIDTH-1:0] w_rd;
      logic                  w_byp0;
      logic                  w_byp1;
      logic                  w_zero;

      assign w_ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      // Forwarding is suppressed during reset so outputs read zero immediately.
      assign w_byp1 = (BYPASS != 0) && !RST && we1 && (waddr1 == w_ra);
      assign w_byp0 = (BYPASS != 0) && !RST && we0 && (waddr0 == w_ra);
      assign w_zero = (ZERO_REG != 0) && (w_ra == '0);

      always_comb begin
        w_rd = r_regs[w_ra];
        if (w_zero)      w_rd = '0;
        else if (w_byp1) w_rd = wdata1;
        else if (w_byp0) w_rd = wdata0;
      end

      assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
      assign rbusy[k] = r_busy[w_ra] & ~w_byp1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the single-cycle MIPS register file. It is generalised in data width, depth and read-port count, and provides two write ports with fixed priority. It adds optional write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard that tracks outstanding multi-cycle results (loads, mul/div). It sits between decode (reads, busy query) and writeback (port 0 = ALU result, port 1 = late/load result).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH
READ_PORTS, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_WIDTH  write address, port 0
wdata0  in  DATA_WIDTH  write data, port 0
we1  in  1  write enable, port 1 (late-result port)
waddr1  in  ADDR_WIDTH  write address, port 1
wdata1  in  DATA_WIDTH  write data, port 1
raddr  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  READ_PORTS*DATA_WIDTH  packed read data, same packing
rbusy  out  READ_PORTS  busy flag for each read address
busy_set  in  1  mark busy_addr as pending
busy_addr  in  ADDR_WIDTH  register to mark pending
busy_vec  out  2**ADDR_WIDTH  full scoreboard, bit i = register i pending

Behaviour:
- Reset (RST high, asynchronous): all registers = 0; all busy bits = 0. Combinational outputs follow: rdata = 0 for every port, rbusy = 0, busy_vec = 0. Writes and busy_set are ignored while RST is high. On deassertion, the first active edge behaves normally.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops, written on the rising CLK edge. Output network is a read mux per port, with no decoded-address read path.
- Write: each enabled port writes its wdata at its waddr on the edge.
  - Both ports enabled, same address: port 1 wins.
  - Different addresses: both written in the same edge.
- ZERO_REG=1: writes to address 0 are dropped, register 0 always reads 0, and busy bit 0 is held 0 (busy_set to 0 is ignored).
- Read: combinational, 0-cycle latency.
  - BYPASS=0: rdata[k] = stored value of raddr[k].
  - BYPASS=1: if we1 and waddr1 == raddr[k], return wdata1. Else if we0 and waddr0 == raddr[k], return wdata0. Else return the stored value. Port 1 takes priority, matching write priority.
  - ZERO_REG takes precedence over bypass for address 0.
- Scoreboard, evaluated on each edge:
  - busy_set sets busy[busy_addr].
  - we1 clears busy[waddr1]. Port 0 writes never clear busy.
  - Same-edge busy_set and we1 to the same address: the bit ends set, because the new pending result wins.
  - busy_set to an already-busy register: stays set, no error.
- rbusy[k] = busy[raddr[k]]. With BYPASS=1, rbusy[k] is masked to 0 when we1 and waddr1 == raddr[k] in the same cycle, because the result is being forwarded now.
- Edge cases:
  - Address width is exact. No out-of-range addresses are possible, and there is no wrap logic.
  - RST asserted mid-cycle with we0/we1 high: no write occurs and contents are 0.
  - Read ports are fully independent. Identical addresses on multiple ports return identical data.

Test Plan:
- Reset: load regs 1..31 with 0xA5A50000+i, assert RST asynchronously between edges -> rdata=0 immediately on all ports, busy_vec=0; after release, reads of reg 5 = 0.
- Dual write collision: we0=we1=1, waddr0=waddr1=7, wdata0=0x11111111, wdata1=0x22222222 -> next cycle reg 7 = 0x22222222. Repeat with waddr0=3, waddr1=4 -> both written.
- Zero reg and bypass: we0=1, waddr0=0, wdata0=0xFFFFFFFF, raddr port0=0 -> rdata 0 both same cycle and next. we0=1 to reg 9 = 0x1234, raddr=9 -> 0x1234 in same cycle (BYPASS=1) and only next cycle (BYPASS=0 build).
- Scoreboard: busy_set reg 12 -> busy_vec[12]=1, rbusy=1 for raddr=12. Three cycles later we1 to 12 with 0xCAFE -> same cycle rbusy=0 and rdata=0xCAFE; next cycle busy_vec[12]=0.
- Set/clear race: reg 20 busy, same edge we1 waddr1=20 and busy_set busy_addr=20 -> busy_vec[20]=1, reg 20 holds new data. busy_set addr 0 -> busy_vec[0]=0.
- Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=3, READ_PORTS=4 -> all four ports read distinct regs 1..4 correctly; packing verified with values 0x0001..0x0004.
